// File: rtl/serial_adder_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the digit-serial adder.
// Consumers: serial_adder_if, serial_adder, digit_adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit configuration still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder; the sub select exists only when ADD_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, a, b, cin,
`ifdef ADD_SUB_EN
        output sub,
`endif
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, a, b, cin,
`ifdef ADD_SUB_EN
        input  sub,
`endif
        output busy, done, s, co, ovf
    );

endinterface

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit ripple-carry adder built from full adders; also reports the carry into its MSB
// so the caller can derive signed overflow.
module digit_adder #(
    parameter int DIGIT = serial_adder_pkg::DEFAULT_DIGIT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock over WIDTH/DIGIT cycles.
// Define ADD_SUB_EN to add the sub port (a - b when sub=1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   s_reg;
    logic               co_reg;
    logic               ovf_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [DIGIT-1:0]   a_dig;
    logic [DIGIT-1:0]   b_dig;
    logic [DIGIT-1:0]   sum_dig;
    logic               dig_cout;
    logic               dig_cmsb;
    logic               last_digit;
    logic [WIDTH-1:0]   b_eff;
    logic               c_init;

    // Subtraction is folded in at latch time: store ~b and force the first carry to 1.
`ifdef ADD_SUB_EN
    assign b_eff  = bus.sub ? ~bus.b : bus.b;
    assign c_init = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff  = bus.b;
    assign c_init = bus.cin;
`endif

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_dig = a_reg[i*DIGIT +: DIGIT];
                b_dig = b_reg[i*DIGIT +: DIGIT];
            end
        end
    end

    assign last_digit = (cnt == CNT_W'(N - 1));

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry),
        .sum  (sum_dig),
        .cout (dig_cout),
        .cmsb (dig_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            co_reg   <= 1'b0;
            ovf_reg  <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg    <= bus.a;
                        b_reg    <= b_eff;
                        carry    <= c_init;
                        cnt      <= '0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            s_reg[i*DIGIT +: DIGIT] <= sum_dig;
                        end
                    end
                    carry <= dig_cout;
                    if (last_digit) begin
                        co_reg   <= dig_cout;
                        ovf_reg  <= dig_cmsb ^ dig_cout;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.s    = s_reg;
    assign bus.co   = co_reg;
    assign bus.ovf  = ovf_reg;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits; must be a multiple of DIGIT.
REQ-002 SHALL have parameter DIGIT, default 4: bits added per clock cycle.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin an addition; sampled only when not busy.
REQ-006 SHALL have ports a, b  input  WIDTH each  operands, sampled on the edge that accepts start.
REQ-007 SHALL have port cin  input  1  carry-in, sampled with the operands.
REQ-008 SHALL have port sub  input  1  subtract select, sampled with the operands; present only when ADD_SUB_EN is defined.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-011 SHALL have port s  output  WIDTH  registered sum.
REQ-012 SHALL have ports co and ovf  output  1 each  unsigned carry-out and two's-complement signed overflow.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE or DONE with start=1, latch a, b, cin (and sub), clear the digit counter, and enter RUN.
REQ-015 SHALL, in RUN, add digit i = bits [i*DIGIT +: DIGIT] plus the carry register each cycle, write the digit sum into s, and update the carry register.
REQ-016 SHALL take N = WIDTH/DIGIT RUN cycles, so done=1 in the cycle after edge N, counting the start-accepting edge as edge 0.
REQ-017 SHALL, after the last digit, enter DONE, set co to the final carry and ovf to (carry into MSB) XOR (carry out of MSB).
REQ-018 SHALL keep done high for exactly one cycle, then go to IDLE unless start=1, in which case it enters RUN (back-to-back operation).
REQ-019 SHALL drive busy=1 in RUN only.
REQ-020 SHALL ignore start while in RUN; no re-latch and no restart.
REQ-021 SHALL hold s, co and ovf stable from DONE until the next accepted start; the digit-wise updates of s during RUN are not valid until done.
REQ-022 SHALL operate correctly for DIGIT = WIDTH (N=1, single RUN cycle).

Reset
REQ-023 SHALL, with rst=1 at a rising edge in any state (including mid-RUN), go to IDLE and clear s, co, ovf, busy, done, the carry register and the counter.
REQ-024 SHALL give rst priority over start on the same edge.

Configuration
REQ-025 SHALL, with ADD_SUB_EN defined, compute a + ~b + 1 when sub=1 (cin ignored, initial carry forced to 1) and a + b + cin when sub=0; co=1 means no borrow.
REQ-026 SHALL, without ADD_SUB_EN, omit the sub port and always compute a + b + cin.

Structure
REQ-027 SHALL place the FSM state encoding and the default WIDTH/DIGIT constants in shared package serial_adder_pkg.
REQ-028 SHALL instantiate one sub-module, digit_adder: a parametrised DIGIT-bit ripple adder built from full adders, with outputs digit sum, carry-out and carry into its MSB.

Verification (WIDTH=16, DIGIT=4)
REQ-029 SHALL cover: a=0x1234, b=0x4321, cin=0 -> s=0x5555, co=0, ovf=0, done at edge 4 after start, busy high 4 cycles.
REQ-030 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, co=1, ovf=0; a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1.
REQ-031 SHALL cover: with ADD_SUB_EN, sub=1, a=0x0005, b=0x0007, cin=1 -> s=0xFFFE, co=0, ovf=0.
REQ-032 SHALL cover: start pulsed during RUN with new operands -> first result unchanged, second start ignored; start held high in DONE -> second result 4 cycles later.
REQ-033 SHALL cover: rst asserted at the second RUN cycle -> next cycle busy=0, done=0, s=0x0000, state IDLE; a fresh start then produces a correct result.
REQ-034 SHALL cover: DIGIT=16, a=0x8000, b=0x8000 -> s=0x0000, co=1, ovf=1, done at edge 1.
